// File: rtl/unary_ops_pkg.sv
// Shared types and helpers for the unary_ops sweep/compactor block.
package unary_ops_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Feedback taps at bits 31, 21, 1 and 0.
  localparam logic [31:0] MISR_POLY = 32'h8020_0003;

  // Width of the reduction-result bus.
  localparam int RED_W = 12;

  // XOR of the two 32-bit chunks of a zero-extended response word.
  // {vec_res, red_res} is at most 60 bits wide, so two chunks always suffice.
  function automatic logic [31:0] fold(input logic [63:0] v);
    return v[31:0] ^ v[63:32];
  endfunction

endpackage

// File: rtl/unary_ops_misr.sv
// 32-bit multiple-input signature register with synchronous clear and enable.
module unary_ops_misr
  import unary_ops_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sig
);

  logic [31:0] sig_q, sig_d;

  // Next signature: shift with tap feedback, then fold in the new word.
  always_comb begin
    sig_d = sig_q;
    if (clr)
      sig_d = '0;
    else if (en)
      sig_d = {sig_q[30:0], ^(sig_q & MISR_POLY)} ^ din;
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/unary_ops_sweep.sv
// Exhaustive input sweep for a unary_ops DUT, with response capture and MISR
// compaction. Optional internal reduction checker: UNARY_OPS_SWEEP_CHECK_EN.
module unary_ops_sweep
  import unary_ops_pkg::*;
#(
  parameter int size = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [size-1:0]       sweep_in,
  input  logic [3*size-1:0]     vec_res,
  input  logic [RED_W-1:0]      red_res,
  output logic                  busy,
  output logic                  done,
  output logic [size:0]         count,
  output logic [31:0]           sig,
  output logic                  err,
  output logic [size-1:0]       err_idx
);

  localparam int               CAP_W     = 3*size + RED_W;
  localparam logic [size-1:0]  SWEEP_MAX = '1;

  state_e             state_q, state_d;
  logic [size-1:0]    sweep_q, sweep_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic               cap_vld_q, cap_vld_d;
  logic [size:0]      count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_acc;

  // start is only honoured when no sweep is in flight.
  assign start_acc = start && (state_q == IDLE || state_q == DONE);

  // Sequencer: drives the sweep, captures responses, counts folds.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    cap_d     = cap_q;
    cap_vld_d = 1'b0;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = done_q;
    // A valid capture is folded one cycle after it was taken.
    if (cap_vld_q) count_d = count_q + (size+1)'(1);
    case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = RUN;
          sweep_d = '0;
          count_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        cap_d     = {vec_res, red_res};
        cap_vld_d = 1'b1;
        if (sweep_q == SWEEP_MAX) state_d = DRAIN;
        else                      sweep_d = sweep_q + size'(1);
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sweep_q   <= '0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  unary_ops_misr u_misr (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    (cap_vld_q),
    .din   (fold(64'(cap_q))),
    .sig   (sig)
  );

`ifdef UNARY_OPS_SWEEP_CHECK_EN
  logic [size-1:0] cap_in_q, cap_in_d;
  logic            err_q, err_d;
  logic [size-1:0] err_idx_q, err_idx_d;
  logic [7:0]      red_exp;

  // Reference reductions of the captured input, in red_res[11:4] order.
  assign red_exp = {~|cap_in_q, &cap_in_q, ~&cap_in_q, |cap_in_q,
                    ~|cap_in_q, ^cap_in_q, ~^cap_in_q, ~^cap_in_q};

  // Checker: remember the input for each capture, latch the first mismatch.
  always_comb begin
    cap_in_d  = (state_q == RUN) ? sweep_q : cap_in_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    if (start_acc) begin
      err_d     = 1'b0;
      err_idx_d = '0;
    end else if (cap_vld_q && !err_q && (cap_q[RED_W-1:4] != red_exp)) begin
      err_d     = 1'b1;
      err_idx_d = cap_in_q;
    end
  end

  // Checker state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_in_q  <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      cap_in_q  <= cap_in_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign err     = err_q;
  assign err_idx = err_idx_q;
`else
  assign err     = 1'b0;
  assign err_idx = '0;
`endif

  assign sweep_in = sweep_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_unary_ops_sweep.sv
// Directed bench for unary_ops_sweep: three instances (size 1, 3, 4), each fed
// by a behavioural unary_ops DUT model.
module tb_unary_ops_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] start_v = '0;
  logic [2:0] rst_v   = '0;
  logic       force0  = 1'b0;
  logic       inj5    = 1'b0;
  logic       inj6    = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural DUT: {bitnot, plus, minus, lognot, and, nand, or, nor, xor,
  // xnor, xnor2, true, false, x->0, z->0}, right-aligned.
  function automatic logic [63:0] resp(input int sz, input int v);
    int m, bn, pl, mn;
    logic par;
    logic [11:0] red;
    m   = (1 << sz) - 1;
    bn  = ~v & m;
    pl  = v & m;
    mn  = (-v) & m;
    par = ($countones(v & m) % 2) == 1;
    red = {v == 0, v == m, v != m, v != 0, v == 0, par, ~par, ~par,
           1'b1, 1'b0, 1'b0, 1'b0};
    return (64'(bn) << (2*sz + 12)) | (64'(pl) << (sz + 12)) |
           (64'(mn) << 12) | 64'(red);
  endfunction

  function automatic logic [31:0] golden(input int sz);
    logic [31:0] s;
    logic [63:0] r;
    s = '0;
    for (int v = 0; v < (1 << sz); v++) begin
      r = resp(sz, v);
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ (r[31:0] ^ r[63:32]);
    end
    return s;
  endfunction

  // size = 1
  logic [0:0]  sw1, ei1;
  logic [2:0]  vec1;
  logic [11:0] red1;
  logic [1:0]  cnt1;
  logic [31:0] sig1;
  logic        busy1, done1, err1;
  assign {vec1, red1} = 15'(resp(1, int'(sw1)));

  // size = 3 (forcing and injection hooks)
  logic [2:0]  sw3, ei3;
  logic [8:0]  vec3;
  logic [11:0] red3, red3_raw;
  logic [3:0]  cnt3;
  logic [31:0] sig3;
  logic        busy3, done3, err3;
  assign {vec3, red3_raw} = 21'(force0 ? 64'd0 : resp(3, int'(sw3)));
  assign red3 = red3_raw ^ {((inj5 && sw3 == 3'd5) || (inj6 && sw3 == 3'd6)), 11'b0};

  // size = 4
  logic [3:0]  sw4, ei4;
  logic [11:0] vec4;
  logic [11:0] red4;
  logic [4:0]  cnt4;
  logic [31:0] sig4;
  logic        busy4, done4, err4;
  assign {vec4, red4} = 24'(resp(4, int'(sw4)));

  unary_ops_sweep #(.size(1)) u_s1 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .sweep_in(sw1),
    .vec_res(vec1), .red_res(red1), .busy(busy1), .done(done1),
    .count(cnt1), .sig(sig1), .err(err1), .err_idx(ei1));

  unary_ops_sweep #(.size(3)) u_s3 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .sweep_in(sw3),
    .vec_res(vec3), .red_res(red3), .busy(busy3), .done(done3),
    .count(cnt3), .sig(sig3), .err(err3), .err_idx(ei3));

  unary_ops_sweep #(.size(4)) u_s4 (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .sweep_in(sw4),
    .vec_res(vec4), .red_res(red4), .busy(busy4), .done(done4),
    .count(cnt4), .sig(sig4), .err(err4), .err_idx(ei4));

  function automatic int sz_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 4;
  endfunction
  function automatic logic [31:0] g_sig(input int s);
    return (s == 0) ? sig1 : (s == 1) ? sig3 : sig4;
  endfunction
  function automatic logic [31:0] g_cnt(input int s);
    return (s == 0) ? 32'(cnt1) : (s == 1) ? 32'(cnt3) : 32'(cnt4);
  endfunction
  function automatic logic [31:0] g_sw(input int s);
    return (s == 0) ? 32'(sw1) : (s == 1) ? 32'(sw3) : 32'(sw4);
  endfunction
  function automatic logic [31:0] g_ei(input int s);
    return (s == 0) ? 32'(ei1) : (s == 1) ? 32'(ei3) : 32'(ei4);
  endfunction
  function automatic logic g_busy(input int s);
    return (s == 0) ? busy1 : (s == 1) ? busy3 : busy4;
  endfunction
  function automatic logic g_done(input int s);
    return (s == 0) ? done1 : (s == 1) ? done3 : done4;
  endfunction
  function automatic logic g_err(input int s);
    return (s == 0) ? err1 : (s == 1) ? err3 : err4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One start pulse, then run until done (bounded). Optional extra start
  // pulse or reset when cyc reaches restart_at / reset_at.
  task automatic sweep(input int s, input int restart_at, input int reset_at, input string tag);
    int cyc;
    int n;
    n = 1 << sz_of(s);
    @(posedge clk); #1 start_v[s] = 1'b1;
    @(posedge clk); #1 start_v[s] = 1'b0;
    chk({tag, "_cnt0"},  g_cnt(s),  32'd0);
    chk({tag, "_sig0"},  g_sig(s),  32'd0);
    chk({tag, "_sw0"},   g_sw(s),   32'd0);
    chk({tag, "_busy0"}, 32'(g_busy(s)), 32'd1);
    chk({tag, "_err0"},  32'(g_err(s)),  32'd0);
    cyc = 0;
    while (!g_done(s) && cyc < 100) begin
      if (cyc == restart_at) start_v[s] = 1'b1;
      if (cyc == reset_at)   rst_v[s]   = 1'b1;
      @(posedge clk); #1;
      cyc++;
      start_v[s] = 1'b0;
      if (rst_v[s]) begin
        rst_v[s] = 1'b0;
        chk({tag, "_rst_busy"}, 32'(g_busy(s)), 32'd0);
        chk({tag, "_rst_done"}, 32'(g_done(s)), 32'd0);
        chk({tag, "_rst_cnt"},  g_cnt(s), 32'd0);
        chk({tag, "_rst_sig"},  g_sig(s), 32'd0);
        chk({tag, "_rst_sw"},   g_sw(s),  32'd0);
        return;
      end
    end
    chk({tag, "_lat"},  32'(cyc), 32'(n + 1));
    chk({tag, "_cnt"},  g_cnt(s), 32'(n));
    chk({tag, "_swN"},  g_sw(s),  32'(n - 1));
    chk({tag, "_busy"}, 32'(g_busy(s)), 32'd0);
  endtask

  initial begin
    rst_v = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_sig",  g_sig(s), 32'd0);
      chk("rst_cnt",  g_cnt(s), 32'd0);
      chk("rst_sw",   g_sw(s),  32'd0);
      chk("rst_busy", 32'(g_busy(s)), 32'd0);
      chk("rst_done", 32'(g_done(s)), 32'd0);
      chk("rst_err",  32'(g_err(s)),  32'd0);
      chk("rst_eidx", g_ei(s), 32'd0);
    end
    rst_v = 3'b000;

    // 1: size 1, hand-computed signature 0x4AB8 then 0xA038.
    sweep(0, -1, -1, "t1");
    chk("t1_sig_hand", sig1, 32'h0000_A038);
    chk("t1_sig_gold", sig1, golden(1));
    chk("t1_done", 32'(done1), 32'd1);

    // 2: size 3, zero responses keep the signature at zero.
    force0 = 1'b1;
    sweep(1, -1, -1, "t2");
    chk("t2_sig", sig3, 32'd0);
    force0 = 1'b0;

    // 3: size 4, start re-pulsed mid-run is ignored.
    sweep(2, 4, -1, "t3");
    chk("t3_sig", sig4, golden(4));

    // 4: size 4, reset mid-run, then a clean sweep.
    sweep(2, -1, 5, "t4");
    sweep(2, -1, -1, "t4b");
    chk("t4b_sig", sig4, golden(4));

    // 5: size 3, lognot inverted at inputs 5 and 6.
    inj5 = 1'b1;
    inj6 = 1'b1;
    sweep(1, -1, -1, "t5");
    inj5 = 1'b0;
    inj6 = 1'b0;
`ifdef UNARY_OPS_SWEEP_CHECK_EN
    chk("t5_err",  32'(err3), 32'd1);
    chk("t5_eidx", 32'(ei3),  32'd5);
`else
    chk("t5_err",  32'(err3), 32'd0);
    chk("t5_eidx", 32'(ei3),  32'd0);
`endif

    // 6: back-to-back sweeps, identical signature; second start clears err.
    sweep(1, -1, -1, "t6a");
    chk("t6a_sig", sig3, golden(3));
    sweep(1, -1, -1, "t6b");
    chk("t6b_sig", sig3, golden(3));
    chk("t6b_err", 32'(err3), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
